// File: rtl/tranif1_switch.sv
// Control-gated bidirectional pass switch built from split in/out/oe nets.
// Each bit is an independent lane; the lanes share only control and direction.

module tranif1_switch_lane (
  input  logic clk,
  input  logic rst,
  input  logic control_i,
  input  logic dir_i,
  input  logic left_i,
  input  logic right_i,
  output logic left_o,
  output logic right_o
);
  logic hold_l_q, hold_l_d;
  logic hold_r_q, hold_r_d;
  logic src;

  // Both keepers follow the driven net, so either side can become the
  // destination after a direction flip and still present the last passed value.
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    src      = dir_i ? right_i : left_i;
    if (control_i) begin
      hold_l_d = src;
      hold_r_d = src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l_q <= 1'b0;
      hold_r_q <= 1'b0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

  assign left_o  = (dir_i  && control_i) ? right_i : hold_l_q;
  assign right_o = (!dir_i && control_i) ? left_i  : hold_r_q;
endmodule

module tranif1_switch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             control,
  input  logic             dir,
  input  logic [WIDTH-1:0] left_i,
  output logic [WIDTH-1:0] left_o,
  output logic             left_oe,
  input  logic [WIDTH-1:0] right_i,
  output logic [WIDTH-1:0] right_o,
  output logic             right_oe
);
  assign right_oe = ~dir;
  assign left_oe  = dir;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    tranif1_switch_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .control_i (control),
      .dir_i     (dir),
      .left_i    (left_i[g]),
      .right_i   (right_i[g]),
      .left_o    (left_o[g]),
      .right_o   (right_o[g])
    );
  end
endmodule

// File: tb/tb_tranif1_switch.sv
// Bench for tranif1_switch: directed scenarios plus random traffic against a
// model that tracks the single value last conducted across the switch.

module tb_tranif1_switch;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, control, dir;
  logic [WIDTH-1:0] left_i, right_i, left_o, right_o;
  logic             left_oe, right_oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Both keepers always load the same source value, so one "last passed" value suffices.
  logic [WIDTH-1:0] kept;

  tranif1_switch #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .dir      (dir),
    .left_i   (left_i),
    .left_o   (left_o),
    .left_oe  (left_oe),
    .right_i  (right_i),
    .right_o  (right_o),
    .right_oe (right_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_model();
    logic [WIDTH-1:0] src, dst_val;
    src     = dir ? right_i : left_i;
    dst_val = control ? src : kept;
    chk("left_oe",  WIDTH'(left_oe),  WIDTH'(dir));
    chk("right_oe", WIDTH'(right_oe), WIDTH'(!dir));
    chk("left_o",   left_o,  dir ? dst_val : kept);
    chk("right_o",  right_o, dir ? kept : dst_val);
  endtask

  // Apply inputs away from the active edge, then check combinational outputs.
  task automatic drive(input logic r, input logic c, input logic d,
                       input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] rr, input bit do_chk = 1'b1);
    @(negedge clk);
    rst = r; control = c; dir = d; left_i = l; right_i = rr;
    #1;
    if (do_chk) check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst)          kept = '0;
    else if (control) kept = dir ? right_i : left_i;
  endtask

  initial begin
    rst = 1'b1; control = 1'b0; dir = 1'b0; left_i = '0; right_i = '0;
    kept = '0;

    drive(1, 0, 0, 8'h00, 8'h00, 1'b0);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    chk("reset_left_o",  left_o,  8'h00);
    chk("reset_right_o", right_o, 8'h00);
    tick();

    // Right-to-left pass and isolation
    drive(0, 1, 1, 8'h00, 8'h01);
    chk("r2l_pass", left_o, 8'h01);
    chk("r2l_loe",  WIDTH'(left_oe),  8'h01);
    chk("r2l_roe",  WIDTH'(right_oe), 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h00, 8'h00);
      chk("r2l_hold", left_o, 8'h01);
      tick();
    end
    drive(0, 1, 1, 8'h00, 8'h00);
    chk("r2l_reclose", left_o, 8'h00);
    tick();

    // Left-to-right pass and isolation
    drive(0, 1, 0, 8'h01, 8'h00);
    chk("l2r_pass", right_o, 8'h01);
    chk("l2r_roe",  WIDTH'(right_oe), 8'h01);
    chk("l2r_loe",  WIDTH'(left_oe),  8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 8'h00, 8'h00);
      chk("l2r_hold", right_o, 8'h01);
      tick();
    end
    drive(0, 1, 0, 8'h00, 8'h00);
    chk("l2r_reclose", right_o, 8'h00);
    tick();

    // Reset clears keepers
    drive(0, 1, 0, 8'h01, 8'h00);
    tick();
    drive(1, 0, 0, 8'h01, 8'h00);
    tick();
    drive(0, 0, 0, 8'h01, 8'h00);
    chk("rst_clears", right_o, 8'h00);
    tick();

    // Reset while conducting still passes combinationally
    drive(1, 1, 0, 8'h5A, 8'h00);
    chk("rst_pass", right_o, 8'h5A);
    tick();
    drive(0, 0, 0, 8'hFF, 8'h00);
    chk("rst_pass_cleared", right_o, 8'h00);
    tick();

    // Direction flip while open
    drive(0, 1, 0, 8'hA5, 8'h00);
    tick();
    drive(0, 0, 1, 8'h00, 8'h3C);
    chk("flip_left_o", left_o, 8'hA5);
    chk("flip_loe", WIDTH'(left_oe),  8'h01);
    chk("flip_roe", WIDTH'(right_oe), 8'h00);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            WIDTH'($urandom), WIDTH'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tranif1_switch.md
Name: tranif1_switch

Overview:
- Synthesizable emulation of a control-gated bidirectional pass switch (tranif1 behaviour) for the fabric routing layer.
- Native inout/tri-state is not used. Each side has separate input, output and output-enable signals, and an explicit direction select.
- When the switch is closed, the driven side's value passes combinationally to the other side.
- When the switch is open, the non-driving side keeps its last passed value through a clocked keeper register.

Parameters:
- WIDTH, 1, bit width of each side's data path.

Ports:
- clk  input  1  system clock; keeper registers update on the rising edge.
- rst  input  1  reset, synchronous, active-high; clears both keeper registers.
- control  input  1  gate: 1 = switch closed (conducting), 0 = switch open (isolated).
- dir  input  1  direction: 0 = left drives right, 1 = right drives left.
- left_i  input  WIDTH  value driven onto the left net by external logic.
- left_o  output  WIDTH  value this block drives onto the left net.
- left_oe  output  1  1 when this block drives the left net.
- right_i  input  WIDTH  value driven onto the right net by external logic.
- right_o  output  WIDTH  value this block drives onto the right net.
- right_oe  output  1  1 when this block drives the right net.

Behaviour:
- Registers: two keepers, hold_l and hold_r, each WIDTH bits. No other state.
- Output enables are combinational, from dir only, and independent of control and rst:
  - dir=0: right_oe=1, left_oe=0.
  - dir=1: left_oe=1, right_oe=0.
- Data outputs, dir=0:
  - right_o = control ? left_i : hold_r
  - left_o = hold_l
- Data outputs, dir=1:
  - left_o = control ? right_i : hold_l
  - right_o = hold_r
- Pass latency is zero cycles; there is no registered stage in the conducting path.
- Keeper update at each rising clk edge:
  - rst=1: hold_l <= 0 and hold_r <= 0. Reset has priority over all other updates.
  - control=1 and dir=0: hold_r <= left_i, and hold_l <= left_i, so the source side's keeper tracks the net it drives.
  - control=1 and dir=1: hold_l <= right_i and hold_r <= right_i.
  - control=0: both keepers hold.
- Opening the switch: after control falls, the destination output presents the value sampled at the last rising edge where control=1. Source-side changes while control=0 have no effect on the destination.
- Closing the switch: the destination follows the source combinationally in the same cycle. The keeper captures the value at the next edge.
- Changing dir while control=1: the output enables and the pass path swap in the same cycle. The keepers then capture the new source value at the next edge.
- Changing dir while control=0: the new destination presents its own keeper value. No transfer occurs.
- Reset mid-operation:
  - With control=1, outputs keep passing combinationally and the keepers clear.
  - With control=0 after a reset edge, the destination reads 0.
- Power-up state before the first reset is undefined; a bench must assert rst for at least one cycle.
- All WIDTH bits behave identically and independently. There is no arithmetic.

Test Plan:
- Right-to-left pass: rst 1 cycle; dir=1, control=1, right_i=1 -> left_o=1 and left_oe=1 in the same cycle; right_oe=0.
- Right-to-left isolation: after the previous step, clock once, then control=0, right_i=0, run 3 cycles -> left_o remains 1; then control=1 -> left_o=0 immediately.
- Left-to-right pass: dir=0, control=1, left_i=1 -> right_o=1, right_oe=1, left_oe=0.
- Left-to-right isolation: clock once, then control=0, left_i=0, run 3 cycles -> right_o stays 1; then control=1 -> right_o=0.
- Reset clears keepers: control=1, left_i=1, clock; assert rst for 1 cycle with control=0 -> right_o=0 after the reset edge.
- Direction flip while open: WIDTH=8. dir=0, control=1, left_i=8'hA5, clock; control=0, dir=1, right_i=8'h3C -> left_o=8'hA5 (keeper), left_oe=1, right_oe=0.
